ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that deserializes scan-code frames from the board ps2_clk/ps2_data pins into bytes. It checks framing and parity, then buffers valid bytes in a small FIFO. It sits upstream of the operand/ALU path and the seg display logic in top. Consumers pop bytes with a single-cycle read strobe.

Parameters:
FIFO_DEPTH, 8, number of buffered bytes; must be a power of 2 and at least 2.
TIMEOUT, 50000, clk cycles with no ps2_clk falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
ps2_clk  input  1  raw keyboard clock; asynchronous to clk.
ps2_data  input  1  raw keyboard data; asynchronous to clk.
rd_en  input  1  pop strobe; one byte consumed per cycle asserted while ready=1.
data  output  8  byte at FIFO head; valid only while ready=1.
ready  output  1  FIFO non-empty.
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky: a valid frame was dropped because the FIFO was full.
frame_err  output  1  one-cycle pulse when a completed frame fails checks.

Behaviour:
- Reset (rst=1 at clk edge): bit counter=0, shift register=0, timeout counter=0, FIFO pointers and count=0, ready=0, data=0, overflow=0, frame_err=0, sync registers=all 1 (idle bus). Reset mid-frame discards the partial frame.
- Input sync: ps2_clk and ps2_data each pass through a 3-flop synchronizer. A falling edge is detected when the two oldest ps2_clk sync stages read 1 then 0. ps2_data is sampled from the synchronized data on that same cycle.
- Frame: 11 bits, captured on successive falling edges: start(0), D0..D7 (LSB first), odd parity, stop(1).
- FSM states:
  - IDLE: bit counter=0. A falling edge with data=0 goes to RECV, bit counter=1. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - RECV: each falling edge shifts in one bit and increments the counter. On the 11th bit, go to CHECK.
  - CHECK: lasts 1 cycle, then returns to IDLE. The frame is valid iff start==0, stop==1, and XOR(D7..D0, parity)==1.
- Valid frame:
  - If the FIFO is not full, push the byte.
  - If the FIFO is full and rd_en is asserted on the same cycle, the pop happens first and the push succeeds; count is unchanged.
  - If the FIFO is full and rd_en=0, drop the byte and set overflow=1.
- Invalid frame: no push, frame_err=1 for exactly that cycle.
- Timeout:
  - In RECV, a counter increments every clk without a falling edge and clears on each falling edge.
  - When it reaches TIMEOUT: return to IDLE, bit counter=0, no push, no frame_err.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - ready = (count!=0). data = mem[rd_ptr], combinational from registered memory/pointer.
  - rd_en while ready=0 is ignored; no pointer underflow.
  - Push and pop on the same cycle with 0<count<FIFO_DEPTH: count unchanged, both pointers advance.
  - A byte pushed at edge N is visible on data/ready after edge N.
- Latency: from the falling edge of the stop bit on the pin to ready=1 is 3 sync cycles + 1 CHECK cycle + 1 write cycle, i.e. 5 clk cycles or fewer.
- overflow clears only on rst.

Test Plan:
- Byte 0x1C, parity bit 0, stop 1, ps2_clk period 20 clk cycles: ready=1 and data=0x1C within 5 cycles of the stop edge; count=1. Then rd_en for 1 cycle: ready=0, count=0.
- Byte 0x1C with parity bit forced to 1: frame_err high for exactly 1 cycle, ready stays 0, count=0.
- 9 valid frames 0x01..0x09 with no reads: count=8, overflow=1. Popping 8 times returns 0x01..0x08 in order; 0x09 is lost.
- 5 bits of a frame, then idle for TIMEOUT+10 cycles, then a full frame of 0xF0 with parity 1: only 0xF0 is stored, count=1, frame_err never pulses.
- FIFO holding 8 bytes, rd_en asserted on the exact cycle frame 0x33 completes: count stays 8, overflow=0, 0x33 is the last byte read out.
- rst asserted after 6 bits of a frame, then a clean frame of 0x5A: FIFO holds only 0x5A, overflow=0.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw ps2_clk/ps2_data pins,
// deserializes 11-bit frames, checks start/stop/odd parity and buffers
// good bytes in a small circular FIFO popped with a one-cycle strobe.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers (idle bus reads as all ones)
  // ---------------------------------------------------------------------
  logic [2:0] clk_sync_reg;
  logic [2:0] data_sync_reg;

  // Three-flop synchronizer chains for both pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 3'b111;
      data_sync_reg <= 3'b111;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[1:0], ps2_data};
    end
  end

  // Falling edge seen on the two oldest stages; data taken from the
  // stage of the same age as the newer clock sample.
  logic fall;
  logic bit_in;
  assign fall   = clk_sync_reg[2] & ~clk_sync_reg[1];
  assign bit_in = data_sync_reg[1];

  // ---------------------------------------------------------------------
  // Frame receiver FSM
  // ---------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [3:0]      bit_cnt_reg, bit_cnt_next;
  logic [10:0]     shift_reg, shift_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 11'd0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end

  // Next-state logic: bits enter at the top so after 11 shifts the start
  // bit sits in [0], data in [8:1], parity in [9] and stop in [10].
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    to_cnt_next  = to_cnt_reg;
    case (state_reg)
      IDLE: begin
        bit_cnt_next = 4'd0;
        to_cnt_next  = '0;
        if (fall && !bit_in) begin
          state_next   = RECV;
          bit_cnt_next = 4'd1;
          shift_next   = {bit_in, shift_reg[10:1]};
        end
      end
      RECV: begin
        if (fall) begin
          shift_next   = {bit_in, shift_reg[10:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          to_cnt_next  = '0;
          if (bit_cnt_reg == 4'd10) begin
            state_next = CHECK;
          end
        end else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
          // Keyboard went quiet mid-frame: abandon it silently.
          state_next   = IDLE;
          bit_cnt_next = 4'd0;
          to_cnt_next  = '0;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      CHECK: begin
        state_next   = IDLE;
        bit_cnt_next = 4'd0;
        to_cnt_next  = '0;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = 4'd0;
        to_cnt_next  = '0;
      end
    endcase
  end

  logic frame_ok;
  logic push_req;
  assign frame_ok  = ~shift_reg[0] & shift_reg[10] & (^shift_reg[9:1]);
  assign push_req  = (state_reg == CHECK) & frame_ok;
  assign frame_err = (state_reg == CHECK) & ~frame_ok;

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;

  logic full;
  logic pop;
  logic push;
  assign full = (count_reg == (AW + 1)'(FIFO_DEPTH));
  assign pop  = rd_en & (count_reg != '0);
  // A pop on the same cycle frees the slot a full FIFO would otherwise lack.
  assign push = push_req & (~full | pop);

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= shift_reg[8:1];
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (push_req && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign ready    = (count_reg != '0);
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign data     = ready ? mem[rd_ptr_reg] : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames on the pins, keeps a
// queue model of the FIFO contents and compares every quiet cycle.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .data(data), .ready(ready), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Per-cycle compare against the queue model while the bus is quiet.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (chk_en) begin
      check("ready", 32'(ready), 32'(exp_q.size() != 0));
      check("count", 32'(count), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("frame_err_quiet", 32'(frame_err), 32'd0);
      if (exp_q.size() != 0) check("data", 32'(data), 32'(exp_q[0]));
    end
  end

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic ps2_fall(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_fall(f[i]);
      ps2_rise();
    end
  endtask

  // What a valid frame does to the FIFO when nobody is reading.
  task automatic frame_model(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    chk_en = 1'b0;
    send_bits(mkframe(b, 1'b0), 11);
    repeat (2) @(negedge clk);
    frame_model(b);
    chk_en = 1'b1;
  endtask

  task automatic pop_one(input logic [7:0] lit);
    @(negedge clk);
    check("pop_value", 32'(data), 32'(lit));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int lat;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    rst      = 1'b1;
    do_reset();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // Single good frame 0x1C, latency from stop edge, then pop.
    f = mkframe(8'h1C, 1'b0);
    check("frame_1c_bits", 32'(f), 32'(11'b1_0_00011100_0));
    chk_en = 1'b0;
    send_bits(f, 10);
    ps2_fall(f[10]);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
    check("latency_within_5", 32'(lat >= 1 && lat <= 5), 32'd1);
    ps2_rise();
    frame_model(8'h1C);
    chk_en = 1'b1;
    @(negedge clk);
    check("t1_data", 32'(data), 32'h1C);
    check("t1_count", 32'(count), 32'd1);
    pop_one(8'h1C);
    @(negedge clk);
    check("t1_ready_after_pop", 32'(ready), 32'd0);
    check("t1_count_after_pop", 32'(count), 32'd0);

    // Bad parity: exactly one frame_err pulse, nothing stored.
    chk_en = 1'b0;
    @(negedge clk);
    err_pulses = 0;
    send_bits(mkframe(8'h1C, 1'b1), 11);
    repeat (3) @(negedge clk);
    check("t2_err_pulses", 32'(err_pulses), 32'd1);
    check("t2_ready", 32'(ready), 32'd0);
    check("t2_count", 32'(count), 32'd0);
    chk_en = 1'b1;

    // Partial frame abandoned by timeout, then a clean 0xF0.
    chk_en = 1'b0;
    @(negedge clk);
    err_pulses = 0;
    f = mkframe(8'hF0, 1'b0);
    check("frame_f0_parity", 32'(f[9]), 32'd1);
    send_bits(mkframe(8'h77, 1'b0), 5);
    repeat (TO + 10) @(negedge clk);
    send_bits(f, 11);
    repeat (3) @(negedge clk);
    check("t4_err_pulses", 32'(err_pulses), 32'd0);
    frame_model(8'hF0);
    chk_en = 1'b1;
    @(negedge clk);
    check("t4_count", 32'(count), 32'd1);
    check("t4_data", 32'(data), 32'hF0);
    pop_one(8'hF0);

    // Nine frames into an eight-deep FIFO: ninth dropped, overflow sticks.
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    @(negedge clk);
    check("t3_count_full", 32'(count), 32'd8);
    check("t3_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop_one(8'(i));
    @(negedge clk);
    check("t3_empty", 32'(ready), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the exact push cycle of 0x33.
    do_reset();
    for (int i = 0; i < 8; i++) send_good(8'hA0 + 8'(i));
    chk_en = 1'b0;
    f = mkframe(8'h33, 1'b0);
    send_bits(f, 10);
    ps2_fall(f[10]);
    repeat (3) @(posedge clk);
    #1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h33);
    ps2_rise();
    chk_en = 1'b1;
    @(negedge clk);
    check("t5_count", 32'(count), 32'd8);
    check("t5_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_one(8'hA0 + 8'(i));
    pop_one(8'h33);

    // Reset in the middle of a frame, then a clean 0x5A.
    chk_en = 1'b0;
    send_bits(mkframe(8'hC3, 1'b0), 6);
    do_reset();
    send_good(8'h5A);
    @(negedge clk);
    check("t6_count", 32'(count), 32'd1);
    check("t6_data", 32'(data), 32'h5A);
    check("t6_overflow", 32'(overflow), 32'd0);
    pop_one(8'h5A);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
